traffic_monitor: RTL

TRAFFIC_MONITOR -- requirements
Module: traffic_monitor

---
 rtl/traffic_monitor.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/traffic_monitor.sv
// traffic_monitor: watches a four-way light controller for illegal codes, bad sequencing and dwell errors.
// Optional macro TRAFFIC_MON_DWELL_CHK_EN adds green/yellow dwell checking (fault codes 5 and 6).
module traffic_monitor #(
   parameter int GREEN_CYC  = 8,
   parameter int YELLOW_CYC = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [2:0] North_lig,
   input  logic [2:0] South_lig,
   input  logic [2:0] East_lig,
   input  logic [2:0] West_lig,
   input  logic       clr_fault,
   output logic       fault,
   output logic [2:0] fault_code,
   output logic       phase_valid,
   output logic [2:0] active_phase,
   output logic [7:0] rot_cnt,
   output logic [1:0] state_dbg_o
);

   typedef enum logic [1:0] {SYNC = 2'd0, TRACK = 2'd1, FAULT = 2'd2} state_e;

   localparam logic [2:0] C_GREEN  = 3'b001;
   localparam logic [2:0] C_YELLOW = 3'b010;
   localparam logic [2:0] C_RED    = 3'b100;

   state_e          state_q;
   logic [3:0][2:0] snap_q;
   logic            fault_q;
   logic [2:0]      code_q;
   logic            valid_q;
   logic [2:0]      phase_q;
   logic [7:0]      rot_q;

   logic            bad_code;
   logic [2:0]      nonred_cnt;
   logic [2:0]      snap_phase;
   logic [2:0]      next_phase;
   logic            legal;
   logic            phase_chg;
   logic [2:0]      err_code;
   logic            overrun;
   logic            underrun;
   logic [2:0]      dwell_code;

   // Clearing the snapshot to all-zero codes makes the first check after reset see an illegal
   // snapshot, which SYNC ignores, so locking happens on the first snapshot taken out of reset.
   always_ff @(posedge clk) begin
      if (!rst) snap_q <= '0;
      else      snap_q <= {West_lig, East_lig, South_lig, North_lig};
   end

   always_comb begin
      bad_code   = 1'b0;
      nonred_cnt = '0;
      snap_phase = '0;
      for (int i = 0; i < 4; i++) begin
         if (snap_q[i] != C_GREEN && snap_q[i] != C_YELLOW && snap_q[i] != C_RED) bad_code = 1'b1;
         if (snap_q[i] == C_GREEN || snap_q[i] == C_YELLOW) begin
            nonred_cnt = nonred_cnt + 3'd1;
            snap_phase = {i[1:0], snap_q[i] == C_YELLOW};
         end
      end
      legal      = !bad_code && (nonred_cnt == 3'd1);
      next_phase = phase_q + 3'd1;
      phase_chg  = legal && (snap_phase != phase_q);
   end

`ifdef TRAFFIC_MON_DWELL_CHK_EN
   localparam logic [3:0] G_LIM = 4'(GREEN_CYC);
   localparam logic [3:0] Y_LIM = 4'(YELLOW_CYC);

   logic [3:0] dwell_q;
   logic       first_q;
   logic [3:0] dwell_lim;

   // dwell_q counts snapshots of the current phase including the one that started it.
   always_comb begin
      dwell_lim  = phase_q[0] ? Y_LIM : G_LIM;
      dwell_code = phase_q[0] ? 3'd6 : 3'd5;
      overrun    = legal && !phase_chg && (dwell_q >= dwell_lim);
      underrun   = phase_chg && !first_q && (dwell_q < dwell_lim);
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         dwell_q <= '0;
         first_q <= 1'b0;
      end else if (state_q == SYNC && legal) begin
         dwell_q <= 4'd1;
         first_q <= 1'b1;
      end else if (state_q == TRACK && err_code == 3'd0) begin
         if (phase_chg) begin
            dwell_q <= 4'd1;
            first_q <= 1'b0;
         end else if (dwell_q != 4'd15) begin
            dwell_q <= dwell_q + 4'd1;
         end
      end
   end
`else
   assign overrun    = 1'b0;
   assign underrun   = 1'b0;
   assign dwell_code = 3'd0;
`endif

   // Lowest code wins when several errors coincide.
   always_comb begin
      err_code = 3'd0;
      if (bad_code)                                    err_code = 3'd1;
      else if (nonred_cnt >= 3'd2)                     err_code = 3'd2;
      else if (nonred_cnt == 3'd0)                     err_code = 3'd3;
      else if (phase_chg && snap_phase != next_phase)  err_code = 3'd4;
      else if (overrun || underrun)                    err_code = dwell_code;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= SYNC;
         fault_q <= 1'b0;
         code_q  <= '0;
         valid_q <= 1'b0;
         phase_q <= '0;
         rot_q   <= '0;
      end else begin
         case (state_q)
            SYNC: begin
               if (legal) begin
                  state_q <= TRACK;
                  valid_q <= 1'b1;
                  phase_q <= snap_phase;
               end
            end
            TRACK: begin
               if (err_code != 3'd0) begin
                  state_q <= FAULT;
                  fault_q <= 1'b1;
                  code_q  <= err_code;
                  valid_q <= 1'b0;
               end else if (phase_chg) begin
                  phase_q <= snap_phase;
                  if (phase_q == 3'd7) rot_q <= rot_q + 8'd1;
               end
            end
            FAULT: begin
               if (clr_fault) begin
                  state_q <= SYNC;
                  fault_q <= 1'b0;
                  code_q  <= '0;
               end
            end
            default: state_q <= SYNC;
         endcase
      end
   end

   assign fault        = fault_q;
   assign fault_code   = code_q;
   assign phase_valid  = valid_q;
   assign active_phase = phase_q;
   assign rot_cnt      = rot_q;
   assign state_dbg_o  = state_q;

endmodule
